i2c_slave_responder: RTL and testbench
======================================

I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h51, 7-bit device address matched against the address byte.
REQ-002 SHALL have input wb_clk_i, 1 bit, system clock; all logic is synchronous to it.
REQ-003 SHALL have input arst_i, 1 bit, reset: asynchronous, active-low.
REQ-004 SHALL have input scl_pad_i, 1 bit, bus SCL level.
REQ-005 SHALL have input sda_pad_i, 1 bit, bus SDA level.
REQ-006 SHALL have output sda_pad_o, 1 bit, tied constant 0 (open-drain).
REQ-007 SHALL have output sda_padoen_o, 1 bit, 0 = pull SDA low, 1 = release.
REQ-008 SHALL have output rx_data_o, 8 bits, last byte written by master.
REQ-009 SHALL have output rx_valid_o, 1 bit, one-cycle strobe qualifying rx_data_o.
REQ-010 SHALL have input tx_data_i, 8 bits, next byte to return on a read.
REQ-011 SHALL have output tx_req_o, 1 bit, one-cycle request for the next tx_data_i.
REQ-012 SHALL have output busy_o, 1 bit, high from START to STOP.

Function
REQ-013 SHALL pass scl_pad_i and sda_pad_i through 2-flop synchronizers plus one history flop each; all edge and condition detection uses the synchronized signals.
REQ-014 SHALL detect START as synced SDA 1->0 while synced SCL is high on both samples, and STOP as SDA 0->1 under the same condition.
REQ-015 SHALL implement states IDLE, ADDR, ACK_ADDR, WRITE, ACK_WR, READ, ACK_RD.
REQ-016 SHALL sample SDA only on a synced SCL rising edge, MSB first, with 8 bits per byte.
REQ-017 SHALL change sda_padoen_o only on a synced SCL falling edge, except on STOP, START or reset.
REQ-018 IDLE: on START -> ADDR, bit counter = 7.
REQ-019 ADDR: after the 8th rising edge -> ACK_ADDR.
- Address match (byte[7:1] == SLAVE_ADDR): drive SDA low from the next falling edge until the following falling edge.
- Mismatch: keep SDA released and go IDLE.
REQ-020 ACK_ADDR exit: R/W = 0 -> WRITE; R/W = 1 -> READ.
REQ-021 WRITE: after the 8th rising edge, load rx_data_o and pulse rx_valid_o for exactly 1 cycle, then drive ACK as in REQ-019 and return to WRITE.
- Bytes per transaction are unlimited.
REQ-022 tx_req_o SHALL pulse for 1 cycle on the rising edge of the address ACK bit (read) and on each master-ACK rising edge in ACK_RD.
REQ-023 tx_data_i SHALL be captured on the next synced SCL falling edge, giving half an SCL period of setup.
REQ-024 READ: on each falling edge, drive the current bit (release for 1, pull low for 0); after 8 bits, release SDA -> ACK_RD.
REQ-025 ACK_RD: SDA = 0 on the rising edge -> READ with a new byte; SDA = 1 (NACK) -> IDLE with SDA released.
REQ-026 A START in any non-IDLE state (repeated START) SHALL release SDA and go to ADDR.
REQ-027 STOP in any state SHALL release SDA, go IDLE and clear busy_o.
REQ-028 If START and a final-bit SCL edge are detected in the same cycle, START SHALL take precedence.
REQ-029 rx_valid_o and tx_req_o SHALL never be high in the same cycle.

Reset
REQ-030 On arst_i low, immediately and regardless of the clock:
- state = IDLE, synchronizers = 1, sda_padoen_o = 1;
- rx_data_o = 8'h00, rx_valid_o = 0, tx_req_o = 0, busy_o = 0.
REQ-031 Reset asserted mid-transaction SHALL release SDA at once; after release, the block SHALL ignore the bus until the next START.

Verification
REQ-032 Write: START, 0xA2, 0xAC, STOP at 100 kHz SCL / 32 MHz clock -> ACK on both bytes; rx_valid_o exactly once with rx_data_o = 0xAC; busy_o returns to 0 after STOP.
REQ-033 Read: START, 0xA3, tx_data_i = 0x5A then 0x3C, master ACK then NACK, STOP -> bus carries 0x5A and 0x3C; tx_req_o pulses exactly twice; SDA released after the NACK.
REQ-034 Mismatch: START, 0xA4, 0x11, STOP -> sda_padoen_o stays 1 throughout; no rx_valid_o or tx_req_o.
REQ-035 Repeated START: START, 0xA2, 0x01, Sr, 0xA3, read 1 byte, NACK, STOP -> rx_data_o = 0x01; read byte equals tx_data_i; states follow REQ-026.
REQ-036 Reset while driving the ACK low -> sda_padoen_o = 1 within the same cycle; a following full write of 0xA2, 0x55 is ACKed normally.
REQ-037 Bench checker SHALL flag any SDA change from the DUT while SCL is high, other than released-bus START/STOP transitions.

Source files
------------

// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - I2C slave byte responder with open-drain SDA drive
// Accepts writes to SLAVE_ADDR and returns host-supplied bytes on reads.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h51
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  output logic       tx_req_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {IDLE, ADDR, ACK_ADDR, WRITE, ACK_WR, READ, ACK_RD} state_t;

  state_t     state, state_nxt;
  logic [2:0] scl_sync, sda_sync;
  logic       scl_s, scl_h, sda_s, sda_h;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] cnt, cnt_nxt;
  logic [7:0] shift, shift_nxt, rx_data_nxt;
  logic       rw, rw_nxt;
  logic       acked, acked_nxt;
  logic       padoen_nxt, rx_valid_nxt, tx_req_nxt, busy_nxt;

  assign sda_pad_o = 1'b0;

  // [0],[1] form the synchronizer, [2] is the history sample used for edge detection
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], scl_pad_i};
      sda_sync <= {sda_sync[1:0], sda_pad_i};
    end
  end

  assign scl_s     = scl_sync[1];
  assign scl_h     = scl_sync[2];
  assign sda_s     = sda_sync[1];
  assign sda_h     = sda_sync[2];
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state        <= IDLE;
      cnt          <= 3'd7;
      shift        <= 8'h00;
      rw           <= 1'b0;
      acked        <= 1'b0;
      sda_padoen_o <= 1'b1;
      rx_data_o    <= 8'h00;
      rx_valid_o   <= 1'b0;
      tx_req_o     <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      shift        <= shift_nxt;
      rw           <= rw_nxt;
      acked        <= acked_nxt;
      sda_padoen_o <= padoen_nxt;
      rx_data_o    <= rx_data_nxt;
      rx_valid_o   <= rx_valid_nxt;
      tx_req_o     <= tx_req_nxt;
      busy_o       <= busy_nxt;
    end
  end

  // STOP beats START, and START beats any same-cycle SCL edge
  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = IDLE;
    end else if (start_det) begin
      state_nxt = ADDR;
    end else begin
      case (state)
        ADDR:
          if (scl_rise && cnt == 3'd0)
            state_nxt = (shift[6:0] == SLAVE_ADDR) ? ACK_ADDR : IDLE;
        ACK_ADDR:
          if (scl_fall && acked)
            state_nxt = rw ? READ : WRITE;
        WRITE:
          if (scl_rise && cnt == 3'd0)
            state_nxt = ACK_WR;
        ACK_WR:
          if (scl_fall && acked)
            state_nxt = WRITE;
        READ:
          if (scl_fall && acked)
            state_nxt = ACK_RD;
        ACK_RD: begin
          if (scl_rise && sda_s)
            state_nxt = IDLE;
          else if (scl_fall && acked)
            state_nxt = READ;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // acked marks the second half of a multi-edge phase (ACK driven, last read bit sent, master ACK seen)
  always_comb begin
    cnt_nxt      = cnt;
    shift_nxt    = shift;
    rw_nxt       = rw;
    acked_nxt    = acked;
    padoen_nxt   = sda_padoen_o;
    rx_data_nxt  = rx_data_o;
    rx_valid_nxt = 1'b0;
    tx_req_nxt   = 1'b0;
    busy_nxt     = busy_o;
    if (stop_det) begin
      padoen_nxt = 1'b1;
      busy_nxt   = 1'b0;
    end else if (start_det) begin
      padoen_nxt = 1'b1;
      busy_nxt   = 1'b1;
      cnt_nxt    = 3'd7;
      acked_nxt  = 1'b0;
    end else begin
      case (state)
        ADDR:
          if (scl_rise) begin
            shift_nxt = {shift[6:0], sda_s};
            if (cnt == 3'd0) begin
              rw_nxt    = sda_s;
              acked_nxt = 1'b0;
            end else begin
              cnt_nxt = cnt - 3'd1;
            end
          end
        ACK_ADDR, ACK_WR: begin
          if (scl_rise && acked && state == ACK_ADDR && rw)
            tx_req_nxt = 1'b1;
          if (scl_fall) begin
            if (!acked) begin
              padoen_nxt = 1'b0;
              acked_nxt  = 1'b1;
            end else begin
              acked_nxt = 1'b0;
              cnt_nxt   = 3'd7;
              if (state == ACK_ADDR && rw) begin
                shift_nxt  = tx_data_i;
                padoen_nxt = tx_data_i[7];
              end else begin
                padoen_nxt = 1'b1;
              end
            end
          end
        end
        WRITE:
          if (scl_rise) begin
            shift_nxt = {shift[6:0], sda_s};
            if (cnt == 3'd0) begin
              rx_data_nxt  = {shift[6:0], sda_s};
              rx_valid_nxt = 1'b1;
              acked_nxt    = 1'b0;
            end else begin
              cnt_nxt = cnt - 3'd1;
            end
          end
        READ: begin
          if (scl_rise) begin
            if (cnt == 3'd0)
              acked_nxt = 1'b1;
            else
              cnt_nxt = cnt - 3'd1;
          end
          if (scl_fall) begin
            if (acked) begin
              padoen_nxt = 1'b1;
              acked_nxt  = 1'b0;
            end else begin
              padoen_nxt = shift[cnt];
            end
          end
        end
        ACK_RD: begin
          if (scl_rise && !sda_s) begin
            tx_req_nxt = 1'b1;
            acked_nxt  = 1'b1;
          end
          if (scl_fall && acked) begin
            shift_nxt  = tx_data_i;
            padoen_nxt = tx_data_i[7];
            cnt_nxt    = 3'd7;
            acked_nxt  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb/tb_i2c_slave_responder.sv - I2C master bench for i2c_slave_responder
// Directed transactions plus randomized ones scored against a byte-level bus model.
`timescale 1ns/1ps
module tb_i2c_slave_responder;

  localparam logic [6:0] DEV = 7'h51;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_pad_o, sda_padoen, rx_valid, tx_req, busy;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;
  logic       scl_bus, sda_bus;

  int vectors = 0, miscompares = 0;
  int rx_count = 0, tx_count = 0, overlap = 0, hi_changes = 0, low_seen = 0;
  logic [7:0] rx_last = 8'h00;
  logic padoen_prev = 1'b1, scl_prev = 1'b1;
  int q = 80;

  always #15.625 clk = ~clk;

  assign scl_bus = scl_m;
  assign sda_bus = sda_m & (sda_padoen | sda_pad_o);

  i2c_slave_responder #(.SLAVE_ADDR(DEV)) dut (
    .wb_clk_i    (clk),
    .arst_i      (arst),
    .scl_pad_i   (scl_bus),
    .sda_pad_i   (sda_bus),
    .sda_pad_o   (sda_pad_o),
    .sda_padoen_o(sda_padoen),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .tx_data_i   (tx_data),
    .tx_req_o    (tx_req),
    .busy_o      (busy)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_count++;
      rx_last = rx_data;
    end
    if (tx_req) tx_count++;
    if (rx_valid && tx_req) overlap++;
    if (!sda_padoen) low_seen++;
    if (arst && scl_bus && scl_prev && (sda_padoen !== padoen_prev)) hi_changes++;
    padoen_prev = sda_padoen;
    scl_prev    = scl_bus;
  end

  function automatic bit addr_match(input logic [7:0] a);
    return a[7:1] == DEV;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cond();
    sda_m = 1'b1; wq(q); scl_m = 1'b1; wq(q); sda_m = 1'b0; wq(q); scl_m = 1'b0; wq(q);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; wq(q); scl_m = 1'b1; wq(q); sda_m = 1'b1; wq(q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wq(q); scl_m = 1'b1; wq(2 * q); scl_m = 1'b0; wq(q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq(q); scl_m = 1'b1; wq(q); b = sda_bus; wq(q); scl_m = 1'b0; wq(q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    ack = ~a;
  endtask

  // next is presented before the master ACK bit so the slave can fetch it
  task automatic read_byte(input logic master_ack, input logic [7:0] next, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    tx_data = next;
    write_bit(~master_ack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d, exp_b, nxt, a;
    int         rx0, tx0, low0, n, nrx;
    bit         m;

    wq(5);
    check("rst_padoen", sda_padoen, 1);
    check("rst_pad_o", sda_pad_o, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_busy", busy, 0);
    arst = 1'b1;
    wq(10);

    rx0 = rx_count;
    start_cond();
    check("wr_busy", busy, 1);
    write_byte(8'hA2, ack);
    check("wr_addr_ack", ack, addr_match(8'hA2));
    write_byte(8'hAC, ack);
    check("wr_data_ack", ack, 1);
    stop_cond();
    check("wr_rx_count", rx_count - rx0, 1);
    check("wr_rx_data", rx_last, 8'hAC);
    check("wr_busy_after_stop", busy, 0);

    tx0 = tx_count;
    tx_data = 8'h5A;
    start_cond();
    write_byte(8'hA3, ack);
    check("rd_addr_ack", ack, 1);
    read_byte(1'b1, 8'h3C, d);
    check("rd_byte0", d, 8'h5A);
    read_byte(1'b0, 8'h00, d);
    check("rd_byte1", d, 8'h3C);
    check("rd_released", sda_padoen, 1);
    stop_cond();
    check("rd_tx_req_count", tx_count - tx0, 2);

    rx0 = rx_count; tx0 = tx_count; low0 = low_seen;
    start_cond();
    write_byte(8'hA4, ack);
    check("mm_addr_ack", ack, addr_match(8'hA4));
    write_byte(8'h11, ack);
    check("mm_data_ack", ack, 0);
    stop_cond();
    check("mm_never_driven", low_seen - low0, 0);
    check("mm_rx_count", rx_count - rx0, 0);
    check("mm_tx_count", tx_count - tx0, 0);

    rx0 = rx_count; tx0 = tx_count;
    exp_b = 8'($urandom);
    tx_data = exp_b;
    start_cond();
    write_byte(8'hA2, ack);
    check("sr_wr_ack", ack, 1);
    write_byte(8'h01, ack);
    check("sr_wr_data_ack", ack, 1);
    start_cond();
    write_byte(8'hA3, ack);
    check("sr_rd_ack", ack, 1);
    read_byte(1'b0, 8'h00, d);
    check("sr_rd_byte", d, exp_b);
    stop_cond();
    check("sr_rx_data", rx_last, 8'h01);
    check("sr_rx_count", rx_count - rx0, 1);
    check("sr_tx_count", tx_count - tx0, 1);

    start_cond();
    for (int i = 7; i >= 0; i--) write_bit(d[i] | 1'b1 ? 8'hA2 >> i : 1'b0);
    sda_m = 1'b1;
    wq(q);
    check("rs_ack_driven", sda_padoen, 0);
    #3 arst = 1'b0;
    #1;
    check("rs_release_now", sda_padoen, 1);
    check("rs_rx_data", rx_data, 8'h00);
    check("rs_busy", busy, 0);
    wq(4);
    arst = 1'b1;
    scl_m = 1'b1; wq(2 * q); scl_m = 1'b0; wq(q);
    rx0 = rx_count; low0 = low_seen;
    write_byte(8'hA2, ack);
    check("rs_ignored_ack", ack, 0);
    check("rs_ignored_low", low_seen - low0, 0);
    stop_cond();
    start_cond();
    write_byte(8'hA2, ack);
    check("rs_wr_addr_ack", ack, 1);
    write_byte(8'h55, ack);
    check("rs_wr_data_ack", ack, 1);
    stop_cond();
    check("rs_rx_count", rx_count - rx0, 1);
    check("rs_rx_data_after", rx_last, 8'h55);

    q = 20;
    for (int t = 0; t < 6; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {DEV, 1'($urandom)};
      n = $urandom_range(1, 2);
      m = addr_match(a);
      rx0 = rx_count; tx0 = tx_count; low0 = low_seen;
      exp_b = 8'($urandom);
      tx_data = exp_b;
      start_cond();
      write_byte(a, ack);
      check("rnd_addr_ack", ack, m);
      if (m && a[0]) begin
        for (int k = 0; k < n; k++) begin
          nxt = 8'($urandom);
          read_byte(k < n - 1, nxt, d);
          check("rnd_rd_byte", d, exp_b);
          exp_b = nxt;
        end
        check("rnd_tx_count", tx_count - tx0, n);
      end else if (!a[0]) begin
        nrx = 0;
        for (int k = 0; k < n; k++) begin
          nxt = 8'($urandom);
          write_byte(nxt, ack);
          check("rnd_wr_ack", ack, m);
          if (m) begin
            nrx++;
            exp_b = nxt;
          end
        end
        check("rnd_rx_count", rx_count - rx0, nrx);
        if (m) check("rnd_rx_data", rx_last, exp_b);
      end
      stop_cond();
      if (!m) check("rnd_mm_low", low_seen - low0, 0);
      check("rnd_busy", busy, 0);
    end

    check("no_rx_tx_overlap", overlap, 0);
    check("no_sda_change_scl_high", hi_changes, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
